// File: rtl/apb_mem_ws.sv
// APB4 word-organised memory slave with byte strobes, a fixed number of wait
// states and PSLVERR for misaligned, out-of-range and read-only accesses.
module apb_mem_ws #(
  parameter int DATA_W      = 32,
  parameter int ADDR_W      = 32,
  parameter int DEPTH       = 256,
  parameter int WAIT_CYCLES = 0,
  parameter int RO_BASE     = DEPTH
) (
  input  logic                PCLK,
  input  logic                PRESETn,
  input  logic                PSEL,
  input  logic                PENABLE,
  input  logic                PWRITE,
  input  logic [ADDR_W-1:0]   PADDR,
  input  logic [DATA_W-1:0]   PWDATA,
  input  logic [DATA_W/8-1:0] PSTRB,
  output logic                PREADY,
  output logic [DATA_W-1:0]   PRDATA,
  output logic                PSLVERR
);

  localparam int STRB_W = DATA_W / 8;
  localparam int OFS_W  = $clog2(STRB_W);
  localparam int IDX_W  = $clog2(DEPTH);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_WAIT  = 2'd1;
  localparam logic [1:0] ST_READY = 2'd2;

  localparam logic [ADDR_W-1:0] DEPTH_A   = ADDR_W'(DEPTH);
  localparam logic [ADDR_W-1:0] RO_BASE_A = ADDR_W'(RO_BASE);
  localparam logic [3:0]        WAIT_INIT = 4'(WAIT_CYCLES);

  logic [DATA_W-1:0] mem [DEPTH];

  logic [1:0]       state;
  logic [3:0]       wcnt;
  logic [IDX_W-1:0] req_idx;
  logic             req_write;
  logic             req_err;

  // Setup-phase decode, taken straight from the bus.
  logic [ADDR_W-1:0] widx;
  logic [IDX_W-1:0]  setup_idx;
  logic              setup;
  logic              setup_err;
  logic [DATA_W-1:0] setup_rdata;
  logic [DATA_W-1:0] req_rdata;
  logic              mem_we;

  assign widx        = PADDR >> OFS_W;
  assign setup_idx   = widx[IDX_W-1:0];
  assign setup       = PSEL && !PENABLE;
  assign setup_err   = (PADDR[OFS_W-1:0] != '0) ||
                       (widx >= DEPTH_A) ||
                       (PWRITE && (widx >= RO_BASE_A));
  assign setup_rdata = (!PWRITE && !setup_err) ? mem[setup_idx] : '0;
  assign req_rdata   = (!req_write && !req_err) ? mem[req_idx] : '0;

  // A write commits only on a completing access; an abort (PSEL low) drops it.
  assign mem_we = (state == ST_READY) && PSEL && PENABLE && req_write && !req_err;

  // NOTE: the array sits under the async reset because its reset contents
  // (mem[i] = i) are architecturally visible; this costs a flop-based RAM.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= DATA_W'(i);
      end
    end else if (mem_we) begin
      for (int b = 0; b < STRB_W; b++) begin
        if (PSTRB[b]) begin
          mem[req_idx][b*8 +: 8] <= PWDATA[b*8 +: 8];
        end
      end
    end
  end

  // NOTE: all state uses non-blocking assignments so every register samples
  // pre-edge values, keeping this block and the memory block order-independent.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state     <= ST_IDLE;
      wcnt      <= '0;
      req_idx   <= '0;
      req_write <= 1'b0;
      req_err   <= 1'b0;
      PREADY    <= 1'b0;
      PRDATA    <= '0;
      PSLVERR   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (setup) begin
            req_idx   <= setup_idx;
            req_write <= PWRITE;
            req_err   <= setup_err;
            wcnt      <= WAIT_INIT;
            if (WAIT_CYCLES == 0) begin
              state   <= ST_READY;
              PREADY  <= 1'b1;
              PSLVERR <= setup_err;
              PRDATA  <= setup_rdata;
            end else begin
              state <= ST_WAIT;
            end
          end
        end

        ST_WAIT: begin
          if (!PSEL) begin
            state <= ST_IDLE;
            wcnt  <= '0;
          end else if (wcnt == 4'd1) begin
            // Read data is sampled here, so a write that just committed is seen.
            state   <= ST_READY;
            wcnt    <= '0;
            PREADY  <= 1'b1;
            PSLVERR <= req_err;
            PRDATA  <= req_rdata;
          end else begin
            wcnt <= wcnt - 4'd1;
          end
        end

        ST_READY: begin
          state   <= ST_IDLE;
          PREADY  <= 1'b0;
          PSLVERR <= 1'b0;
          PRDATA  <= '0;
        end

        default: begin
          state   <= ST_IDLE;
          wcnt    <= '0;
          PREADY  <= 1'b0;
          PSLVERR <= 1'b0;
          PRDATA  <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_apb_mem_ws.sv
// Scoreboard bench for apb_mem_ws: a zero-wait slave with a read-only upper
// half and a three-wait-state slave share one APB bus with separate selects.
module tb_apb_mem_ws;

  logic        PCLK = 1'b0;
  logic        PRESETn;
  logic        psel;
  logic        PENABLE;
  logic        PWRITE;
  logic [31:0] PADDR;
  logic [31:0] PWDATA;
  logic [3:0]  PSTRB;
  logic        cur_dut;

  logic        psel_a, psel_b;
  logic        pready_a, pready_b;
  logic        pslverr_a, pslverr_b;
  logic [31:0] prdata_a, prdata_b;
  logic        cur_pready, cur_pslverr;
  logic [31:0] cur_prdata;

  assign psel_a      = psel & ~cur_dut;
  assign psel_b      = psel & cur_dut;
  assign cur_pready  = cur_dut ? pready_b  : pready_a;
  assign cur_pslverr = cur_dut ? pslverr_b : pslverr_a;
  assign cur_prdata  = cur_dut ? prdata_b  : prdata_a;

  apb_mem_ws #(.DATA_W(32), .ADDR_W(32), .DEPTH(256), .WAIT_CYCLES(0), .RO_BASE(128)) dut_a (
    .PCLK(PCLK), .PRESETn(PRESETn), .PSEL(psel_a), .PENABLE(PENABLE), .PWRITE(PWRITE),
    .PADDR(PADDR), .PWDATA(PWDATA), .PSTRB(PSTRB),
    .PREADY(pready_a), .PRDATA(prdata_a), .PSLVERR(pslverr_a)
  );

  apb_mem_ws #(.DATA_W(32), .ADDR_W(32), .DEPTH(256), .WAIT_CYCLES(3)) dut_b (
    .PCLK(PCLK), .PRESETn(PRESETn), .PSEL(psel_b), .PENABLE(PENABLE), .PWRITE(PWRITE),
    .PADDR(PADDR), .PWDATA(PWDATA), .PSTRB(PSTRB),
    .PREADY(pready_b), .PRDATA(prdata_b), .PSLVERR(pslverr_b)
  );

  always #5 PCLK = ~PCLK;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          waits;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;

  localparam logic DUT_A = 1'b0;
  localparam logic DUT_B = 1'b1;

  // One complete transfer; returns at the negedge inside the PREADY=1 cycle so
  // a following call starts the next setup phase with no idle gap.
  task automatic apb_xfer(input logic dut, input logic wr, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [3:0] strb,
                          input logic [31:0] exp_rdata, input logic exp_err,
                          input int exp_waits, input string name);
    exp_t e;
    exp_t got;
    int   n;
    @(negedge PCLK);
    cur_dut = dut;
    total++;
    if (cur_pready !== 1'b0) begin
      bad++;
      $display("FAIL %s idle_pready: got=%b exp=0", name, cur_pready);
    end
    psel = 1'b1; PENABLE = 1'b0; PWRITE = wr; PADDR = addr; PWDATA = wdata; PSTRB = strb;
    e.rdata = exp_rdata; e.err = exp_err; e.waits = exp_waits;
    exp_q.push_back(e);
    @(negedge PCLK);
    PENABLE = 1'b1;
    n = 0;
    while (cur_pready !== 1'b1 && n <= 40) begin
      total++;
      if (cur_prdata !== 32'h0 || cur_pslverr !== 1'b0) begin
        bad++;
        $display("FAIL %s wait_outputs: got prdata=%h pslverr=%b exp 0/0", name, cur_prdata, cur_pslverr);
      end
      n++;
      @(negedge PCLK);
    end
    got = exp_q.pop_front();
    total++;
    if (n > 40) begin
      bad++;
      $display("FAIL %s timeout: PREADY not seen within 40 cycles, exp waits=%0d", name, got.waits);
    end else begin
      if (n !== got.waits) begin
        bad++;
        $display("FAIL %s wait_count: got=%0d exp=%0d", name, n, got.waits);
      end
      total++;
      if (cur_prdata !== got.rdata) begin
        bad++;
        $display("FAIL %s prdata: got=%h exp=%h", name, cur_prdata, got.rdata);
      end
      total++;
      if (cur_pslverr !== got.err) begin
        bad++;
        $display("FAIL %s pslverr: got=%b exp=%b", name, cur_pslverr, got.err);
      end
    end
  endtask

  task automatic bus_idle(input int cycles);
    repeat (cycles) begin
      @(negedge PCLK);
      psel = 1'b0; PENABLE = 1'b0;
    end
  endtask

  task automatic check_outputs_zero(input string name);
    total++;
    if ({pready_a, pslverr_a, prdata_a, pready_b, pslverr_b, prdata_b} !== '0) begin
      bad++;
      $display("FAIL %s: got a=%b/%b/%h b=%b/%b/%h exp all 0", name,
               pready_a, pslverr_a, prdata_a, pready_b, pslverr_b, prdata_b);
    end
  endtask

  task automatic test_reset();
    PRESETn = 1'b0; psel = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
    PADDR = '0; PWDATA = '0; PSTRB = '0; cur_dut = DUT_A;
    repeat (3) @(negedge PCLK);
    check_outputs_zero("reset_outputs");
    PRESETn = 1'b1;
    bus_idle(2);
  endtask

  task automatic test_reset_contents();
    apb_xfer(DUT_A, 1'b0, 32'h000, '0, 4'h0, 32'h0000_0000, 1'b0, 0, "rd_0x000");
    apb_xfer(DUT_A, 1'b0, 32'h3FC, '0, 4'h0, 32'h0000_00FF, 1'b0, 0, "rd_0x3fc");
    bus_idle(1);
  endtask

  task automatic test_byte_strobes();
    apb_xfer(DUT_A, 1'b1, 32'h010, 32'hAABB_CCDD, 4'b0101, 32'h0, 1'b0, 0, "wr_strb_0x10");
    apb_xfer(DUT_A, 1'b0, 32'h010, '0, 4'h0, 32'h00BB_00DD, 1'b0, 0, "rd_strb_0x10");
    apb_xfer(DUT_A, 1'b1, 32'h014, 32'hFFFF_FFFF, 4'b0000, 32'h0, 1'b0, 0, "wr_nostrb_0x14");
    apb_xfer(DUT_A, 1'b0, 32'h014, '0, 4'h0, 32'h0000_0005, 1'b0, 0, "rd_nostrb_0x14");
    bus_idle(1);
  endtask

  task automatic test_wait_states();
    apb_xfer(DUT_B, 1'b0, 32'h020, '0, 4'h0, 32'h0000_0008, 1'b0, 3, "ws_rd_0x20");
    apb_xfer(DUT_B, 1'b0, 32'h3FC, '0, 4'h0, 32'h0000_00FF, 1'b0, 3, "ws_rd_0x3fc");
    bus_idle(1);
  endtask

  task automatic test_errors();
    apb_xfer(DUT_A, 1'b0, 32'h401, '0, 4'h0, 32'h0, 1'b1, 0, "err_misaligned_rd");
    apb_xfer(DUT_A, 1'b1, 32'h400, 32'h1111_1111, 4'hF, 32'h0, 1'b1, 0, "err_range_wr");
    apb_xfer(DUT_A, 1'b0, 32'h400, '0, 4'h0, 32'h0, 1'b1, 0, "err_range_rd");
    apb_xfer(DUT_A, 1'b1, 32'h200, 32'h1234_5678, 4'hF, 32'h0, 1'b1, 0, "err_ro_wr");
    apb_xfer(DUT_A, 1'b0, 32'h200, '0, 4'h0, 32'h0000_0080, 1'b0, 0, "ro_rd_0x200");
    apb_xfer(DUT_A, 1'b1, 32'h1FC, 32'hC0DE_0001, 4'hF, 32'h0, 1'b0, 0, "wr_last_rw");
    apb_xfer(DUT_A, 1'b0, 32'h1FC, '0, 4'h0, 32'hC0DE_0001, 1'b0, 0, "rd_last_rw");
    apb_xfer(DUT_B, 1'b0, 32'h402, '0, 4'h0, 32'h0, 1'b1, 3, "ws_err_misaligned");
    bus_idle(1);
  endtask

  task automatic test_back_to_back();
    apb_xfer(DUT_A, 1'b1, 32'h008, 32'hDEAD_BEEF, 4'hF, 32'h0, 1'b0, 0, "b2b_wr_a");
    apb_xfer(DUT_A, 1'b0, 32'h008, '0, 4'h0, 32'hDEAD_BEEF, 1'b0, 0, "b2b_rd_a");
    apb_xfer(DUT_B, 1'b1, 32'h008, 32'hDEAD_BEEF, 4'hF, 32'h0, 1'b0, 3, "b2b_wr_b");
    apb_xfer(DUT_B, 1'b0, 32'h008, '0, 4'h0, 32'hDEAD_BEEF, 1'b0, 3, "b2b_rd_b");
    bus_idle(1);
  endtask

  // Drives a write, holds PSEL for hold_cycles access cycles, then drops it.
  task automatic abort_write(input logic dut, input logic [31:0] addr, input int hold_cycles,
                             input string name);
    @(negedge PCLK);
    cur_dut = dut;
    psel = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = addr; PWDATA = 32'hFFFF_FFFF; PSTRB = 4'hF;
    repeat (hold_cycles) begin
      @(negedge PCLK);
      PENABLE = 1'b1;
    end
    @(negedge PCLK);
    psel = 1'b0; PENABLE = 1'b0;
    @(negedge PCLK);
    check_outputs_zero(name);
  endtask

  task automatic test_abort();
    abort_write(DUT_B, 32'h004, 2, "abort_wait_outputs");
    apb_xfer(DUT_B, 1'b0, 32'h004, '0, 4'h0, 32'h0000_0001, 1'b0, 3, "abort_wait_rd");
    abort_write(DUT_A, 32'h018, 0, "abort_ready_outputs");
    apb_xfer(DUT_A, 1'b0, 32'h018, '0, 4'h0, 32'h0000_0006, 1'b0, 0, "abort_ready_rd");
    bus_idle(1);
  endtask

  task automatic test_reset_mid();
    @(negedge PCLK);
    cur_dut = DUT_A;
    psel = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = 32'h008; PWDATA = 32'h1111_1111; PSTRB = 4'hF;
    @(negedge PCLK);
    PENABLE = 1'b1;
    total++;
    if (pready_a !== 1'b1) begin
      bad++;
      $display("FAIL rst_mid_pre_pready: got=%b exp=1", pready_a);
    end
    #1 PRESETn = 1'b0;
    #1 check_outputs_zero("rst_mid_outputs");
    @(negedge PCLK);
    psel = 1'b0; PENABLE = 1'b0;
    PRESETn = 1'b1;
    apb_xfer(DUT_A, 1'b0, 32'h008, '0, 4'h0, 32'h0000_0002, 1'b0, 0, "rst_rd_a_0x08");
    apb_xfer(DUT_A, 1'b0, 32'h010, '0, 4'h0, 32'h0000_0004, 1'b0, 0, "rst_rd_a_0x10");
    apb_xfer(DUT_B, 1'b0, 32'h008, '0, 4'h0, 32'h0000_0002, 1'b0, 3, "rst_rd_b_0x08");
    bus_idle(2);
  endtask

  initial begin
    test_reset();
    test_reset_contents();
    test_byte_strobes();
    test_wait_states();
    test_errors();
    test_back_to_back();
    test_abort();
    test_reset_mid();
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_drain: got=%0d entries exp=0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, exp completion earlier");
    $fatal(1);
  end

endmodule
